// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron MAC datapath and its layer controller.
// sat_signed clamps a sign-extended value into a narrower signed range; relu zeroes negatives.
package neuron_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam int NN_DATA_W   = 8;
    localparam int NN_ACC_W    = 20;
    localparam int NN_N_INPUTS = 16;

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned     width);
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (width - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (v > mx)
            return mx;
        else if (v < mn)
            return mn;
        else
            return v;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] v);
        return (v < 0) ? 64'sd0 : v;
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed clamp from an IN_W-bit value to the OUT_W-bit signed range.
module sat_clamp
    import neuron_pkg::*;
#(
    parameter int IN_W  = 21,
    parameter int OUT_W = 20
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val
);

    logic signed [63:0] w_ext;
    logic signed [63:0] w_res;

    assign w_ext = 64'(i_val);
    assign w_res = sat_signed(w_ext, OUT_W);
    assign o_val = w_res[OUT_W-1:0];

endmodule

// File: rtl/neuron_mac.sv
// Handshaked signed MAC for one neuron: bias + sum(weight*in) over N_INPUTS beats,
// saturating accumulator, optional ReLU, arithmetic shift and clamp to DATA_W.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int N_INPUTS = 16,
    parameter int SHIFT    = 0,
    parameter int RELU     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic signed [ACC_W-1:0]  i_bias,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic signed [DATA_W-1:0] i_weight,
    input  logic signed [DATA_W-1:0] i_in,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic signed [DATA_W-1:0] o_out,
    output logic                     o_acc_sat,
    output logic                     o_busy
);

    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    localparam int PROD_W = 2 * DATA_W;

    state_t                    r_state;
    state_t                    w_next;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_w;
    logic signed [DATA_W-1:0]  r_x;
    logic                      r_opv;
    logic                      r_sat;
    logic [CNT_W-1:0]          r_cnt;

    logic                      w_fire;
    logic                      w_last;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W:0]     w_sum;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic                      w_acc_clamp;
    logic signed [ACC_W-1:0]   w_shr;
    logic signed [63:0]        w_shr64;
    logic signed [63:0]        w_act;
    logic signed [DATA_W-1:0]  w_res;

    assign w_fire = (r_state == S_ACCUM) && i_in_valid;
    assign w_last = w_fire && (r_cnt == CNT_W'(N_INPUTS - 1));

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start)
                    w_next = S_ACCUM;
            end
            S_ACCUM: begin
                o_in_ready = 1'b1;
                if (w_last)
                    w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_OUT;
            S_OUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The ACC_W+1 sum cannot overflow, so the clamp flag is just "clamp changed the value".
    assign w_prod      = PROD_W'(r_w) * PROD_W'(r_x);
    assign w_sum       = {r_acc[ACC_W-1], r_acc}
                       + {{(ACC_W + 1 - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_clamp = (w_sum != {w_acc_next[ACC_W-1], w_acc_next});

    sat_clamp #(.IN_W(ACC_W + 1), .OUT_W(ACC_W)) u_acc_clamp (
        .i_val (w_sum),
        .o_val (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_w   <= '0;
            r_x   <= '0;
            r_opv <= 1'b0;
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_acc <= i_bias;
            r_opv <= 1'b0;
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_opv <= w_fire;
            if (w_fire) begin
                r_w   <= i_weight;
                r_x   <= i_in;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_opv) begin
                r_acc <= w_acc_next;
                if (w_acc_clamp)
                    r_sat <= 1'b1;
            end
        end
    end

    assign w_shr   = r_acc >>> SHIFT;
    assign w_shr64 = 64'(w_shr);
    assign w_act   = (RELU != 0) ? relu(w_shr64) : w_shr64;

    sat_clamp #(.IN_W(64), .OUT_W(DATA_W)) u_out_clamp (
        .i_val (w_act),
        .o_val (w_res)
    );

    assign o_out     = (r_state == S_OUT) ? w_res : '0;
    assign o_acc_sat = r_sat;

endmodule

// File: tb/tb_neuron_mac.sv
// Drives three neuron_mac configurations (ReLU, no-ReLU, SHIFT=2) in lockstep from a
// vector table and compares each result against scoreboard entries queued at start.
module tb_neuron_mac;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam int NI = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 i_start = 1'b0;
    logic signed [AW-1:0] i_bias = '0;
    logic                 i_in_valid = 1'b0;
    logic signed [DW-1:0] i_weight = '0;
    logic signed [DW-1:0] i_in = '0;
    logic                 i_out_ready = 1'b1;

    logic                 rdy [3];
    logic                 vld [3];
    logic                 sat [3];
    logic                 bsy [3];
    logic signed [DW-1:0] dout [3];

    always #5 clk = ~clk;

    neuron_mac #(.DATA_W(DW), .ACC_W(AW), .N_INPUTS(NI), .SHIFT(0), .RELU(1)) u_relu (
        .clk(clk), .reset(reset), .i_start(i_start), .i_bias(i_bias),
        .i_in_valid(i_in_valid), .o_in_ready(rdy[0]), .i_weight(i_weight), .i_in(i_in),
        .o_out_valid(vld[0]), .i_out_ready(i_out_ready), .o_out(dout[0]),
        .o_acc_sat(sat[0]), .o_busy(bsy[0]));

    neuron_mac #(.DATA_W(DW), .ACC_W(AW), .N_INPUTS(NI), .SHIFT(0), .RELU(0)) u_lin (
        .clk(clk), .reset(reset), .i_start(i_start), .i_bias(i_bias),
        .i_in_valid(i_in_valid), .o_in_ready(rdy[1]), .i_weight(i_weight), .i_in(i_in),
        .o_out_valid(vld[1]), .i_out_ready(i_out_ready), .o_out(dout[1]),
        .o_acc_sat(sat[1]), .o_busy(bsy[1]));

    neuron_mac #(.DATA_W(DW), .ACC_W(AW), .N_INPUTS(NI), .SHIFT(2), .RELU(1)) u_shr (
        .clk(clk), .reset(reset), .i_start(i_start), .i_bias(i_bias),
        .i_in_valid(i_in_valid), .o_in_ready(rdy[2]), .i_weight(i_weight), .i_in(i_in),
        .o_out_valid(vld[2]), .i_out_ready(i_out_ready), .o_out(dout[2]),
        .o_acc_sat(sat[2]), .o_busy(bsy[2]));

    typedef struct {
        logic signed [AW-1:0]  bias;
        logic [NI-1:0][DW-1:0] w;
        logic signed [DW-1:0]  x;
        logic signed [DW-1:0]  e_relu;
        logic signed [DW-1:0]  e_lin;
        logic signed [DW-1:0]  e_shr;
        logic                  e_sat;
    } vec_t;

    typedef struct {
        logic signed [DW-1:0] o_relu;
        logic signed [DW-1:0] o_lin;
        logic signed [DW-1:0] o_shr;
        logic                 sat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[9];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int b, input int w0, input int w1, input int w2,
                                input int w3, input int x, input int er, input int el,
                                input int es, input bit s);
        vec_t v;
        v.bias   = AW'(b);
        v.w[0]   = DW'(w0);
        v.w[1]   = DW'(w1);
        v.w[2]   = DW'(w2);
        v.w[3]   = DW'(w3);
        v.x      = DW'(x);
        v.e_relu = DW'(er);
        v.e_lin  = DW'(el);
        v.e_shr  = DW'(es);
        v.e_sat  = s;
        return v;
    endfunction

    // gaps: random in_valid bubbles; stall: cycles of out_ready low in OUT;
    // st_out: start pulse while stalled; st_hs: start on the handshake edge.
    task automatic run_vec(input vec_t v, input bit gaps, input int stall,
                           input bit st_out, input bit st_hs);
        exp_t e;
        int   t;
        i_start = 1'b1;
        i_bias  = v.bias;
        tick();
        i_start = 1'b0;
        i_bias  = '0;
        sb.push_back('{v.e_relu, v.e_lin, v.e_shr, v.e_sat});
        chk("in_ready_accum", 32'(rdy[0]), 1);
        for (int k = 0; k < NI; k++) begin
            if (gaps) begin
                i_in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            i_in_valid = 1'b1;
            i_weight   = v.w[k];
            i_in       = v.x;
            tick();
        end
        i_in_valid = 1'b0;
        chk("drain_no_valid", 32'(vld[0]), 0);
        t = 0;
        while (!vld[0] && t < 8) begin
            tick();
            t++;
        end
        chk("valid_latency", t, 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (stall > 0) begin
            i_out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                i_start = st_out && (s == 1);
                tick();
                i_start = 1'b0;
                chk("stall_valid", 32'(vld[0]), 1);
                chk("stall_out", dout[0], e.o_relu);
                chk("stall_sat", 32'(sat[0]), 32'(e.sat));
            end
            i_out_ready = 1'b1;
        end
        chk("out_relu", dout[0], e.o_relu);
        chk("out_lin", dout[1], e.o_lin);
        chk("out_shr", dout[2], e.o_shr);
        chk("acc_sat", 32'(sat[0]), 32'(e.sat));
        chk("valid_lin_shr", 32'({vld[1], vld[2]}), 3);
        i_start = st_hs;
        tick();
        i_start = 1'b0;
        chk("idle_busy", 32'(bsy[0]), 0);
        chk("idle_valid", 32'(vld[0]), 0);
        chk("idle_out_zero", dout[1], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = mk(0, 2, 3, -1, 4, 10, 80, 80, 20, 0);
        vt[1] = mk(0, -5, -5, -5, -5, 10, 0, -128, 0, 0);
        vt[2] = mk(0, 127, 127, 127, 127, 127, 127, 127, 127, 0);
        vt[3] = mk(524000, 127, 127, 127, 127, 127, 127, 127, 127, 1);
        vt[4] = mk(-8, 1, 1, 1, 1, 3, 4, 4, 1, 0);
        vt[5] = mk(-524000, -128, -128, -128, -128, 127, 0, -128, 0, 1);
        vt[6] = mk(0, -128, -128, -128, -128, -128, 127, 127, 127, 0);
        vt[7] = mk(100, 0, 0, 0, 0, 5, 100, 100, 25, 0);
        vt[8] = mk(-3, 0, 0, 0, 0, 0, 0, -3, 0, 0);

        reset = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", 32'(rdy[0]), 0);
        chk("rst_out_valid", 32'(vld[0]), 0);
        chk("rst_out", dout[0], 0);
        chk("rst_acc_sat", 32'(sat[0]), 0);
        chk("rst_busy", 32'(bsy[0]), 0);
        reset = 1'b0;
        tick();

        foreach (vt[i]) run_vec(vt[i], 1'b0, 0, 1'b0, 1'b0);

        run_vec(vt[0], 1'b1, 5, 1'b1, 1'b0);
        run_vec(vt[3], 1'b1, 5, 1'b0, 1'b0);
        run_vec(vt[1], 1'b0, 0, 1'b0, 1'b1);
        chk("hs_start_ignored", 32'(bsy[0]), 0);

        // Abort after two beats; the partial sum must not surface.
        i_start = 1'b1;
        i_bias  = '0;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_in_valid = 1'b1;
            i_weight   = vt[0].w[k];
            i_in       = vt[0].x;
            tick();
        end
        i_in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("midrst_in_ready", 32'(rdy[0]), 0);
        chk("midrst_valid", 32'(vld[0]), 0);
        chk("midrst_busy", 32'(bsy[0]), 0);
        reset = 1'b0;
        tick();
        run_vec(vt[0], 1'b0, 0, 1'b0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Parametrised, handshaked multiply-accumulate unit computing one neuron pre-activation (bias + Σ weight·input over N_INPUTS beats), with optional ReLU and saturation to the output width. It is the next-generation MAC engine in the neural-network datapath. A layer controller instantiates one per neuron and streams weight/input pairs into it. Compared with the earlier fixed 8-bit MAC it adds signed arithmetic, a wide saturating accumulator, beat counting, and valid/ready flow control on both sides.

## Interface
- DATA_W, 8, signed width of weight, input and out
- ACC_W, 20, signed accumulator width (≥ 2·DATA_W)
- N_INPUTS, 16, beats per neuron evaluation (≥ 1)
- SHIFT, 0, arithmetic right shift applied to accumulator before output clamp
- RELU, 1, 1 = clamp negative results to 0
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  pulse; begins evaluation, loads bias (honoured only in IDLE)
- bias  in  ACC_W  signed initial accumulator value, sampled with start
- in_valid  in  1  weight/in pair valid
- in_ready  out  1  high only in ACCUM
- weight  in  DATA_W  signed weight
- in  in  DATA_W  signed activation
- out_valid  out  1  result valid (OUT state)
- out_ready  in  1  consumer accepts result
- out  out  DATA_W  signed result; 0 whenever out_valid=0
- acc_sat  out  1  sticky: accumulator saturated during this evaluation
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCUM, DRAIN, OUT.
- IDLE: on start, acc←bias, beat count←0, acc_sat←0, operand-valid←0, go to ACCUM. in_valid is ignored.
- ACCUM: in_ready=1. On each in_valid&&in_ready edge, register weight/in into the operand stage, set operand-valid, and increment the count. When the N_INPUTS-th beat is accepted, go to DRAIN.
- Stage 2, every edge with operand-valid: acc ← sat_ACC_W(acc + w·x). The full 2·DATA_W signed product is sign-extended to ACC_W. On clamp, set acc_sat.
- DRAIN: single cycle for the last product to land, then go to OUT.
- OUT: out_valid=1. out = clamp_DATA_W(RELU && r<0 ? 0 : r), where r = acc >>> SHIFT. The result holds stable until out_valid&&out_ready, then the FSM goes to IDLE.
- start outside IDLE is ignored. in_valid outside ACCUM is not accepted.
- out_valid&&out_ready and a start on the same edge: the start is ignored. A new start is honoured from IDLE on the next cycle.
- Reset values: state IDLE; in_ready, out_valid, out, acc_sat, busy = 0. acc, count and operand registers = 0.

## Timing
- Last beat accepted at edge E0 → acc final at edge E1 → out_valid high from E1 (second edge counting the acceptance).
- Minimum evaluation: 1 (start) + N_INPUTS + 1 (DRAIN) cycles, plus ≥1 cycle in OUT.
- in_valid gaps stall the count without penalty; there is no input bubble between beats.
- out_ready may be held low indefinitely. out, acc_sat and out_valid stay constant meanwhile.
- Reset mid-operation takes effect on the next edge. Any partial sum is discarded and no out_valid is produced.

## Structure
- Package neuron_pkg:
  - state enum for IDLE/ACCUM/DRAIN/OUT
  - functions sat_signed(value, width) and relu
  - shared width constants for the layer controller
- One natural sub-module: sat_clamp, a combinational signed clamp from wide to narrow. It is used twice: for the ACC_W accumulate and for the DATA_W output.

## Test plan
All scenarios use DATA_W=8, ACC_W=20, N_INPUTS=4, SHIFT=0 unless stated.
- Basic sum: bias=0, weights 2,3,-1,4, inputs 10 each, back-to-back → out=80, acc_sat=0. out_valid rises two edges after the 4th acceptance.
- Negative result: weights -5 ×4, inputs 10, bias=0, -200 in total → RELU=1 gives out=0; RELU=0 gives out=-128.
- Saturation: weights 127, inputs 127:
  - bias=0, 64516 in total → out=127, acc_sat=0.
  - bias=524000 → acc clamps at 524287, acc_sat=1, out=127.
- Flow control: random in_valid gaps, and out_ready low for 5 cycles → same result as the gapless run. out is stable while stalled. A start pulse during OUT is ignored.
- Reset mid-op: reset after 2 beats → next cycle in_ready=0, out_valid=0, busy=0. A fresh start with scenario-1 data then gives out=80.
- Shift/bias: SHIFT=2, bias=-8, weights 1, inputs 3 → acc=4, out=1.
